// File: rtl/mem_test_pkg.sv
// Shared state and pattern-mode encodings for the memory verification blocks.
package mem_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADDR  = 2'd0,
        MODE_NADDR = 2'd1,
        MODE_SEED  = 2'd2,
        MODE_WALK1 = 2'd3
    } mode_t;

endpackage

// File: rtl/mem_pattern.sv
// Combinational expected-data generator; shared by the verifier and the pattern writer.
module mem_pattern
    import mem_test_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] SEED       = 16'hA5A5
) (
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] expected
);

    logic [DATA_WIDTH-1:0] w_addr_ext;

    always_comb begin
        w_addr_ext = DATA_WIDTH'(addr);
        expected   = w_addr_ext;
        case (mode_t'(mode))
            MODE_ADDR:  expected = w_addr_ext;
            MODE_NADDR: expected = ~w_addr_ext;
            MODE_SEED:  expected = SEED;
            MODE_WALK1: expected = DATA_WIDTH'(1) << addr[3:0];
            default:    expected = w_addr_ext;
        endcase
    end

endmodule

// File: rtl/mem_verify.sv
// Read-only BRAM checker: sweeps BASE_ADDR..LAST_ADDR and counts words differing from a pattern.
// Define MEM_VERIFY_STOP_ON_ERR_EN to end a pass at the first mismatch.
module mem_verify
    import mem_test_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           BASE_ADDR  = 0,
    parameter int unsigned           LAST_ADDR  = 1023,
    parameter logic [DATA_WIDTH-1:0] SEED       = 16'hA5A5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam logic [ADDR_WIDTH-1:0] L_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] L_LAST = ADDR_WIDTH'(LAST_ADDR);

    state_t                r_state;
    state_t                w_next;
    mode_t                 r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_addr_d;
    logic                  r_cmp_v;
    logic [ADDR_WIDTH:0]   r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_addr;
    logic [DATA_WIDTH-1:0] r_first_data;
    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_mismatch;
    logic                  w_launch;

    // Pattern is evaluated on the delayed address so it lines up with q.
    mem_pattern #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .SEED      (SEED)
    ) u_pattern (
        .mode    (r_mode),
        .addr    (r_addr_d),
        .expected(w_expected)
    );

    assign w_mismatch = r_cmp_v && (q != w_expected);
    assign w_launch   = start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = READ;
            READ:    if (r_addr == L_LAST) w_next = DRAIN;
            DRAIN:   w_next = DONE;
            DONE:    if (start) w_next = READ;
            default: w_next = IDLE;
        endcase
`ifdef MEM_VERIFY_STOP_ON_ERR_EN
        if (w_mismatch) w_next = DONE;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_mode       <= MODE_ADDR;
            r_addr       <= '0;
            r_addr_d     <= '0;
            r_cmp_v      <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
        end else begin
            r_state  <= w_next;
            r_addr_d <= r_addr;
            // A read issued on the edge that ends the pass early must not be compared.
            r_cmp_v  <= (r_state == READ) && (w_next != DONE);
            if (w_launch) begin
                r_addr       <= L_BASE;
                r_mode       <= mode_t'(mode);
                r_err_count  <= '0;
                r_first_addr <= '0;
                r_first_data <= '0;
            end else begin
                if ((r_state == READ) && (r_addr != L_LAST))
                    r_addr <= r_addr + 1'b1;
                if (w_mismatch) begin
                    if (r_err_count != '1)
                        r_err_count <= r_err_count + 1'b1;
                    if (r_err_count == '0) begin
                        r_first_addr <= r_addr_d;
                        r_first_data <= q;
                    end
                end
            end
        end
    end

    assign addr           = r_addr;
    assign busy           = (r_state == READ) || (r_state == DRAIN);
    assign done           = (r_state == DONE);
    assign pass           = (r_state == DONE) && (r_err_count == '0);
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_addr;
    assign first_err_data = r_first_data;

endmodule

// File: tb/tb_mem_verify.sv
// Scoreboard bench for mem_verify: full-range instance plus a single-word (BASE == LAST) instance.
`timescale 1ns/1ps
module tb_mem_verify;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;
`ifdef MEM_VERIFY_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        int inst;
        int lat;
        int err;
        int faddr;
        int fdata;
        int pass;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_v [2];
    logic [1:0]    mode_v  [2];
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] q_v     [2];
    logic          busy_v  [2];
    logic          done_v  [2];
    logic          pass_v  [2];
    logic [AW:0]   err_v   [2];
    logic [AW-1:0] fa_v    [2];
    logic [DW-1:0] fd_v    [2];
    logic          prev_done [2];

    logic [DW-1:0] mem [0:(1<<AW)-1];
    exp_t sb [$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   start_cyc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        q_v[0] <= mem[addr_v[0]];
        q_v[1] <= mem[addr_v[1]];
    end

    mem_verify #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0), .LAST_ADDR(1023), .SEED(16'hA5A5)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]), .addr(addr_v[0]),
        .q(q_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .first_err_addr(fa_v[0]), .first_err_data(fd_v[0])
    );

    mem_verify #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(1023), .LAST_ADDR(1023), .SEED(16'hA5A5)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]), .addr(addr_v[1]),
        .q(q_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .first_err_addr(fa_v[1]), .first_err_data(fd_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a rising done completes one pass; pop and compare its expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (done_v[i] === 1'b1 && prev_done[i] !== 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_done: inst %0d got done=1 expected no pending pass", i);
                end else begin
                    e = sb.pop_front();
                    check("inst",       i,                    e.inst);
                    check("latency",    cyc - start_cyc[i],   e.lat);
                    check("err_count",  err_v[i],             e.err);
                    check("first_addr", fa_v[i],              e.faddr);
                    check("first_data", fd_v[i],              e.fdata);
                    check("pass",       pass_v[i],            e.pass);
                end
            end
            prev_done[i] <= done_v[i];
        end
    end

    task automatic expect_pass(input int inst, input int lat, input int err,
                               input int fa, input int fd, input int ok);
        exp_t e;
        e.inst = inst; e.lat = lat; e.err = err; e.faddr = fa; e.fdata = fd; e.pass = ok;
        sb.push_back(e);
    endtask

    task automatic start_pass(input int inst, input logic [1:0] m);
        @(negedge clk);
        mode_v[inst]  = m;
        start_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_cyc[inst] = cyc;
        start_v[inst]   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL timeout: got %0d passes pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic fill(input int kind);
        for (int a = 0; a < (1 << AW); a++) begin
            case (kind)
                0:       mem[a] = DW'(a);
                1:       mem[a] = ~DW'(a);
                2:       mem[a] = 16'hA5A5;
                default: mem[a] = DW'(1) << (a % 16);
            endcase
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},  addr_v[0], 0);
        check({tag, "_busy"},  busy_v[0], 0);
        check({tag, "_done"},  done_v[0], 0);
        check({tag, "_pass"},  pass_v[0], 0);
        check({tag, "_err"},   err_v[0],  0);
        check({tag, "_faddr"}, fa_v[0],   0);
        check({tag, "_fdata"}, fd_v[0],   0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_v[i]   = 1'b0;
            mode_v[i]    = 2'd0;
            prev_done[i] = 1'b0;
            start_cyc[i] = 0;
        end
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Clean address image, mode 0.
        expect_pass(0, 1025, 0, 0, 0, 1);
        start_pass(0, 2'd0);
        drain(1200);

        // Single corrupted word.
        mem[5] = 16'h0000;
        expect_pass(0, STOP ? 7 : 1025, 1, 5, 0, 0);
        start_pass(0, 2'd0);
        drain(1200);

        // Restart from DONE clears counters; a second start mid-pass is ignored.
        mem[5] = 16'h0005;
        expect_pass(0, 1025, 0, 0, 0, 1);
        start_pass(0, 2'd0);
        check("restart_err", err_v[0], 0);
        check("restart_fa", fa_v[0], 0);
        check("restart_busy", busy_v[0], 1);
        repeat (98) @(posedge clk);
        @(negedge clk);
        mode_v[0]  = 2'd1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        drain(1200);

        // Seed image with two corruptions, including the last address.
        fill(2);
        mem[16'h010] = 16'h0000;
        mem[16'h3FF] = 16'h1234;
        expect_pass(0, STOP ? 18 : 1025, STOP ? 1 : 2, 16'h010, 0, 0);
        start_pass(0, 2'd2);
        drain(1200);

        // Every word mismatches, first one at BASE_ADDR.
        fill(0);
        expect_pass(0, STOP ? 2 : 1025, STOP ? 1 : 1024, 0, 0, 0);
        start_pass(0, 2'd1);
        drain(1200);

        // Walking-one image.
        fill(3);
        expect_pass(0, 1025, 0, 0, 0, 1);
        start_pass(0, 2'd3);
        drain(1200);

        // Reset mid-pass abandons it; no compares until the next start.
        fill(1);
        mem[16'h020] = 16'h0000;
        start_pass(0, 2'd1);
        repeat (299) @(posedge clk);
        #2;
        check("pre_rst_busy", busy_v[0], 1);
        check("pre_rst_err", err_v[0], 1);
        check("pre_rst_fa", fa_v[0], 16'h020);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_zero("postrst");
        mem[16'h020] = ~16'h0020;
        expect_pass(0, 1025, 0, 0, 0, 1);
        start_pass(0, 2'd1);
        drain(1200);

        // Single-word pass at the top of the address space.
        mem[16'h3FF] = 16'h8000;
        expect_pass(1, 2, 0, 0, 0, 1);
        start_pass(1, 2'd3);
        drain(20);
        mem[16'h3FF] = 16'h0001;
        expect_pass(1, 2, 1, 16'h3FF, 16'h0001, 0);
        start_pass(1, 2'd3);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_verify.md
MEM_VERIFY -- requirements
Module: mem_verify

Interface
REQ-001 Parameter DATA_WIDTH, default 16, memory word width.
REQ-002 Parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 Parameter BASE_ADDR, default 0, first address checked.
REQ-004 Parameter LAST_ADDR, default 1023, last address checked; BASE_ADDR <= LAST_ADDR; N = LAST_ADDR-BASE_ADDR+1.
REQ-005 Parameter SEED, default 16'hA5A5, constant used by pattern mode 2.
REQ-006 Ports SHALL be:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a verify pass when sampled high in IDLE or DONE
- mode  in  2  expected-data pattern, sampled with start
- addr  out  ADDR_WIDTH  read address to the BRAM read port
- q  in  DATA_WIDTH  BRAM read data; valid one cycle after addr is presented
- busy  out  1  high in READ and DRAIN
- done  out  1  high in DONE
- pass  out  1  high in DONE when err_count == 0
- err_count  out  ADDR_WIDTH+1  number of mismatching words, saturating
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch
- first_err_data  out  DATA_WIDTH  data read at the first mismatch

Function
REQ-007 mem_verify SHALL only read memory; it has no write-enable or write-data output.
REQ-008 Expected data SHALL be: mode 0 = address zero-extended; mode 1 = bitwise NOT of mode 0; mode 2 = SEED; mode 3 = 1 << address[3:0] (walking one).
REQ-009 State machine SHALL be IDLE, READ, DRAIN, DONE.
REQ-010 IDLE/DONE -> READ when start is sampled high: addr <= BASE_ADDR, err_count and first_err_* <= 0, mode latched.
REQ-011 In READ, addr SHALL increment by 1 each cycle; READ -> DRAIN on the edge after addr == LAST_ADDR was presented (READ lasts exactly N cycles).
REQ-012 DRAIN -> DONE after one cycle; done SHALL be high from the (N+1)th rising edge after the edge that samples start.
REQ-013 Compare SHALL use the address delayed by one cycle against q; each mismatch increments err_count, saturating at 2^(ADDR_WIDTH+1)-1.
REQ-014 On the first mismatch of a pass, first_err_addr/first_err_data SHALL capture the delayed address and q; later mismatches SHALL NOT overwrite them.
REQ-015 start SHALL be ignored while busy; DONE holds outputs until the next start.
REQ-016 BASE_ADDR == LAST_ADDR SHALL run a one-word pass (READ one cycle).

Reset
REQ-017 rst low SHALL immediately force IDLE, addr = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_err_addr = 0, first_err_data = 0, latched mode = 0.
REQ-018 Reset mid-pass SHALL abandon the pass; the in-flight read is discarded and no compare occurs after reset release until a new start.

Configuration
REQ-019 Macro MEM_VERIFY_STOP_ON_ERR_EN defined: on the first mismatch the FSM SHALL go directly to DONE on the next edge, err_count = 1, pass = 0, remaining addresses unread.
REQ-020 Macro undefined: every address BASE_ADDR..LAST_ADDR SHALL be checked regardless of mismatches.

Structure
REQ-021 Shared package mem_test_pkg SHALL hold the state encodings (IDLE=0, READ=1, DRAIN=2, DONE=3) and mode codes (MODE_ADDR, MODE_NADDR, MODE_SEED, MODE_WALK1).
REQ-022 Expected-data generation SHALL be one combinational sub-module, mem_pattern (inputs mode, addr; output expected), reusable by the pattern writer.

Verification
REQ-023 BRAM preloaded with data = address, mode 0, start pulse -> done after N+1 = 1025 cycles, pass = 1, err_count = 0.
REQ-024 Same image, word 0x005 corrupted to 0x0000 -> err_count = 1, first_err_addr = 0x005, first_err_data = 0x0000, pass = 0.
REQ-025 Image all 0xA5A5, mode 2, words 0x010 and 0x3FF corrupted -> err_count = 2, first_err_addr = 0x010; with MEM_VERIFY_STOP_ON_ERR_EN, done 18 cycles after start edge, err_count = 1.
REQ-026 Image = ~address, mode 1, rst driven low at cycle 300 -> all outputs zero, state IDLE; new start -> pass = 1.
REQ-027 start pulsed again at cycle 100 of a pass -> ignored, done still at cycle 1025; start in DONE -> counters cleared, new pass begins.
REQ-028 BASE_ADDR = LAST_ADDR = 0x3FF, mode 3, word = 0x8000 -> READ one cycle, done 2 cycles after start edge, pass = 1.
